// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and FSM state encoding for the MIPS fetch unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] FN_JR    = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && (fn == FN_JR);
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Decode/control inputs and fetch outputs of the fetch unit; slave is the unit itself.
interface mips_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              halt_req;
    logic              resume;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       jaddr;
    logic [ADDR_W-1:0] rs_value;
    logic              branch_taken;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic [ADDR_W-1:0] link_addr;
    logic              ras_mispredict;
    logic              ras_overflow;
    logic              ras_underflow;
    logic [1:0]        state;

    modport master (
        output stall, halt_req, resume, opcode, funct, imm, jaddr, rs_value, branch_taken,
        input  pc, pc_valid, link_addr, ras_mispredict, ras_overflow, ras_underflow, state
    );

    modport slave (
        input  stall, halt_req, resume, opcode, funct, imm, jaddr, rs_value, branch_taken,
        output pc, pc_valid, link_addr, ras_mispredict, ras_overflow, ras_underflow, state
    );

endinterface

// File: rtl/mips_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched.
module mips_ras #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]  r_sp;
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_top_idx;

    assign w_top_idx = r_sp - 1'b1;
    assign o_top     = r_stack[w_top_idx];
    assign o_full    = (r_count == DEPTH_CNT);
    assign o_empty   = (r_count == '0);

    // With the depth a power of two, the write slot after a full wrap is exactly the oldest entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stack <= '{default: '0};
            r_sp    <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_stack[r_sp] <= i_push_data;
            r_sp          <= r_sp + 1'b1;
            if (!o_full)
                r_count <= r_count + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp    <= r_sp - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// PC sequencer with J/JAL/JR/branch selection, a return-address stack and a run/stall/halt FSM.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    mips_fetch_if.slave   bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_jtarget;
    logic [ADDR_W-1:0] w_btarget;
    logic              w_pc_valid;
    logic              w_retire;
    logic              w_is_jump;
    logic              w_is_jal;
    logic              w_is_jr;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_full;
    logic              w_ras_empty;
    logic              r_mispredict;
    logic              r_overflow;
    logic              r_underflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  w_next_state = ST_RUN;
            ST_RUN: begin
                if (bus.halt_req)
                    w_next_state = ST_HALT;
                else if (bus.stall)
                    w_next_state = ST_STALL;
            end
            ST_STALL: begin
                if (bus.halt_req)
                    w_next_state = ST_HALT;
                else if (!bus.stall)
                    w_next_state = ST_RUN;
            end
            ST_HALT: begin
                if (bus.resume)
                    w_next_state = ST_RUN;
            end
        endcase
    end

    // An instruction retires only in RUN with neither halt_req nor stall; everything else holds.
    always_comb begin
        w_pc_valid = (r_state == ST_RUN) || (r_state == ST_STALL);
        w_retire   = (r_state == ST_RUN) && !bus.halt_req && !bus.stall;
        w_is_jump  = (bus.opcode == OP_J);
        w_is_jal   = (bus.opcode == OP_JAL);
        w_is_jr    = is_jr(bus.opcode, bus.funct);
        w_push     = w_retire && w_is_jal;
        w_pop      = w_retire && w_is_jr;
    end

    assign w_pc_plus1 = r_pc + 1'b1;
    assign w_jtarget  = {w_pc_plus1[ADDR_W-1:26], bus.jaddr};
    assign w_btarget  = w_pc_plus1 + {{(ADDR_W-16){bus.imm[15]}}, bus.imm};

    always_comb begin
        w_pc_next = r_pc;
        if (w_retire) begin
            if (w_is_jump || w_is_jal)
                w_pc_next = w_jtarget;
            else if (w_is_jr)
                w_pc_next = bus.rs_value;
            else if (bus.branch_taken)
                w_pc_next = w_btarget;
            else
                w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_pc <= RESET_VEC;
        else
            r_pc <= w_pc_next;
    end

    mips_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_plus1),
        .o_top       (w_ras_top),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mispredict <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mispredict <= w_pop && !w_ras_empty && (w_ras_top != bus.rs_value);
            if (w_push && w_ras_full)
                r_overflow <= 1'b1;
            if (w_pop && w_ras_empty)
                r_underflow <= 1'b1;
        end
    end

    assign bus.pc             = r_pc;
    assign bus.pc_valid       = w_pc_valid;
    assign bus.link_addr      = w_pc_plus1;
    assign bus.ras_mispredict = r_mispredict;
    assign bus.ras_overflow   = r_overflow;
    assign bus.ras_underflow  = r_underflow;
    assign bus.state          = r_state;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: reset, wrap, call/return, RAS limits, branch, stall/halt.
module tb_mips_fetch_unit;

    logic clock;
    logic reset_n;
    int   n_run;
    int   n_fail;

    mips_fetch_if #(.ADDR_W(32)) bus ();

    mips_fetch_unit #(
        .ADDR_W    (32),
        .RAS_DEPTH (4),
        .RESET_VEC (32'h0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        bus.stall        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
        bus.opcode       = 6'd0;
        bus.funct        = 6'd0;
        bus.imm          = 16'h0;
        bus.jaddr        = 26'h0;
        bus.rs_value     = 32'h0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] target);
        nop();
        bus.opcode = op;
        bus.jaddr  = target;
    endtask

    task automatic set_jr(input logic [31:0] rs);
        nop();
        bus.opcode   = 6'd0;
        bus.funct    = 6'd8;
        bus.rs_value = rs;
    endtask

    task automatic set_br(input logic [15:0] off);
        nop();
        bus.branch_taken = 1'b1;
        bus.imm          = off;
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        nop();
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_flags", {29'd0, bus.ras_overflow, bus.ras_underflow, bus.ras_mispredict}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        chk("idle_state", 32'(bus.state), 32'd0);
        chk("idle_valid", 32'(bus.pc_valid), 32'd0);
        step();
        chk("run_state", 32'(bus.state), 32'd1);
        chk("run_valid", 32'(bus.pc_valid), 32'd1);
        chk("run_pc", bus.pc, 32'h0);
        chk("run_link", bus.link_addr, 32'h1);

        // 0 + 1 - 2 lands on all-ones, then sequential fetch wraps to 0
        set_br(16'hFFFE);
        step();
        chk("br_to_max", bus.pc, 32'hFFFF_FFFF);
        nop();
        step();
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_flags", {29'd0, bus.ras_overflow, bus.ras_underflow, bus.ras_mispredict}, 32'd0);

        set_j(6'd2, 26'h20);
        step();
        chk("j_0x20", bus.pc, 32'h20);
        set_br(16'hFFFC);
        step();
        chk("br_back", bus.pc, 32'h1D);

        set_j(6'd2, 26'h10);
        step();
        chk("j_0x10", bus.pc, 32'h10);
        set_j(6'd3, 26'h40);
        chk("jal_link", bus.link_addr, 32'h11);
        step();
        chk("jal_pc", bus.pc, 32'h40);
        set_jr(32'h11);
        step();
        chk("jr_ok_pc", bus.pc, 32'h11);
        chk("jr_ok_mp", 32'(bus.ras_mispredict), 32'd0);

        set_j(6'd2, 26'h10);
        step();
        set_j(6'd3, 26'h40);
        step();
        set_jr(32'h12);
        step();
        chk("jr_bad_pc", bus.pc, 32'h12);
        chk("jr_bad_mp", 32'(bus.ras_mispredict), 32'd1);
        nop();
        step();
        chk("mp_pulse_end", 32'(bus.ras_mispredict), 32'd0);
        chk("seq_pc", bus.pc, 32'h13);

        for (int i = 0; i < 4; i++) begin
            set_j(6'd3, 26'h100);
            step();
        end
        chk("four_jal_pc", bus.pc, 32'h100);
        chk("four_jal_ovf", 32'(bus.ras_overflow), 32'd0);
        set_j(6'd3, 26'h100);
        step();
        chk("fifth_jal_ovf", 32'(bus.ras_overflow), 32'd1);

        for (int i = 0; i < 4; i++) begin
            set_jr(32'h101);
            step();
        end
        chk("four_jr_pc", bus.pc, 32'h101);
        chk("four_jr_mp", 32'(bus.ras_mispredict), 32'd0);
        chk("four_jr_unf", 32'(bus.ras_underflow), 32'd0);
        for (int i = 0; i < 2; i++) begin
            set_jr(32'h200);
            step();
        end
        chk("six_jr_pc", bus.pc, 32'h200);
        chk("six_jr_unf", 32'(bus.ras_underflow), 32'd1);
        chk("six_jr_mp", 32'(bus.ras_mispredict), 32'd0);
        chk("ovf_sticky", 32'(bus.ras_overflow), 32'd1);

        nop();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.pc, 32'h200);
        end
        chk("stall_state", 32'(bus.state), 32'd2);
        chk("stall_valid", 32'(bus.pc_valid), 32'd1);
        bus.stall = 1'b0;
        step();
        chk("unstall_state", 32'(bus.state), 32'd1);
        chk("unstall_pc", bus.pc, 32'h200);

        set_j(6'd2, 26'h300);
        bus.halt_req = 1'b1;
        step();
        chk("halt_state", 32'(bus.state), 32'd3);
        chk("halt_pc", bus.pc, 32'h200);
        chk("halt_valid", 32'(bus.pc_valid), 32'd0);
        bus.halt_req = 1'b0;
        step();
        chk("halt_hold_pc", bus.pc, 32'h200);
        bus.resume = 1'b1;
        step();
        chk("resume_state", 32'(bus.state), 32'd1);
        chk("resume_pc", bus.pc, 32'h200);
        bus.resume = 1'b0;
        step();
        chk("j_after_resume", bus.pc, 32'h300);

        set_j(6'd3, 26'h50);
        step();
        nop();
        bus.halt_req = 1'b1;
        step();
        chk("halt2_state", 32'(bus.state), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_halt_pc", bus.pc, 32'h0);
        chk("rst_halt_state", 32'(bus.state), 32'd0);
        chk("rst_halt_flags", {29'd0, bus.ras_overflow, bus.ras_underflow, bus.ras_mispredict}, 32'd0);
        nop();
        step();
        reset_n = 1'b1;
        step();
        chk("rerun_state", 32'(bus.state), 32'd1);
        set_jr(32'h55);
        step();
        chk("post_rst_jr_pc", bus.pc, 32'h55);
        chk("post_rst_unf", 32'(bus.ras_underflow), 32'd1);
        chk("post_rst_mp", 32'(bus.ras_mispredict), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
